// File: rtl/rx_comma_sync_ctrl.sv
// Serial receive controller: deserialises the bit stream, aligns on the comma symbol and
// delivers aligned payload bytes once the link has seen enough consecutive aligned commas.
module rx_comma_sync_ctrl #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned COMMA_LOCK = 4
) (
    input  logic       clk32f,
    input  logic       reset,
    input  logic       in_rx_tx,
    input  logic       realign,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       comma_det
);

    typedef enum logic [1:0] {StSearch, StAlign, StActive} state_e;

    localparam logic [3:0] LockCnt = 4'(COMMA_LOCK);

    state_e     state_q, state_d;
    // Only the seven most recent bits are needed to form the candidate word with the new bit.
    logic [6:0] sr_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] comma_cnt_q, comma_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       comma_det_q, comma_det_d;

    logic [7:0] word;
    logic       is_comma;
    logic       boundary;

    assign word     = {sr_q, in_rx_tx};
    assign is_comma = (word == COMMA);
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        comma_det_d = 1'b0;

        if (realign) begin
            state_d     = StSearch;
            bit_cnt_d   = 3'd0;
            comma_cnt_d = 4'd0;
            valid_d     = 1'b0;
        end else begin
            case (state_q)
                StSearch: begin
                    bit_cnt_d = 3'd0;
                    valid_d   = 1'b0;
                    if (is_comma) begin
                        state_d     = StAlign;
                        comma_cnt_d = 4'd1;
                        comma_det_d = 1'b1;
                    end
                end
                StAlign: begin
                    if (boundary) begin
                        if (is_comma) begin
                            comma_det_d = 1'b1;
                            data_d      = word;
                            if (comma_cnt_q < LockCnt) begin
                                comma_cnt_d = comma_cnt_q + 4'd1;
                            end
                            if (comma_cnt_q + 4'd1 == LockCnt) begin
                                state_d = StActive;
                            end
                        end else begin
                            state_d     = StSearch;
                            comma_cnt_d = 4'd0;
                            bit_cnt_d   = 3'd0;
                        end
                    end
                end
                StActive: begin
                    // Alignment is frozen here; off-boundary commas are ordinary data bits.
                    if (boundary) begin
                        data_d      = word;
                        valid_d     = !is_comma;
                        comma_det_d = is_comma;
                    end
                end
                default: begin
                    state_d = StSearch;
                end
            endcase
        end
    end

    always_ff @(posedge clk32f or posedge reset) begin
        if (reset) begin
            state_q     <= StSearch;
            sr_q        <= 7'd0;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            comma_det_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= word[6:0];
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            comma_det_q <= comma_det_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = (state_q == StActive);
    assign comma_det = comma_det_q;

endmodule
